// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, monitor FSM encoding and the CRC-16 step
// used for per-frame golden-image signatures.
package vga_pkg;

  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_LEN   = 640;
  localparam int H_FRONT     = 16;

  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_LEN   = 480;
  localparam int V_FRONT     = 10;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_LOCKED   = 2'd2
  } mon_state_t;

  // One 12-bit pixel per step, MSB (R[3]) shifted in first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [11:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_stream_monitor_if.sv
// Video pins into the monitor plus its per-frame results.
// Handshake: every signal is sampled only on clk edges where pixpulse=1;
// frame_done is a single-clk qualifier for the frame_* result fields.
interface vga_stream_monitor_if;
  import vga_pkg::*;

  logic        pixpulse;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_crc;
  logic [18:0] lit_count;
  logic [11:0] probe_rgb;
  logic [9:0]  meas_lines;
  logic        timing_err;
  mon_state_t  dbg_state;

  modport master (
    output pixpulse, hsync, vsync, rgb,
    input  locked, frame_done, frame_crc, lit_count, probe_rgb, meas_lines,
           timing_err, dbg_state
  );

  modport slave (
    input  pixpulse, hsync, vsync, rgb,
    output locked, frame_done, frame_crc, lit_count, probe_rgb, meas_lines,
           timing_err, dbg_state
  );
endinterface

// File: rtl/vga_sync_tracker.sv
// Recovers pixel/line position from sync leading edges and flags lines or
// frames whose length does not match the nominal totals.
module vga_sync_tracker #(
  parameter int H_TOTAL         = vga_pkg::H_TOTAL,
  parameter int V_TOTAL         = vga_pkg::V_TOTAL,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pixpulse,
  input  logic       i_hsync,
  input  logic       i_vsync,
  output logic [9:0] o_hc,
  output logic [9:0] o_vc,
  output logic       o_hs_start,
  output logic       o_vs_start,
  output logic       o_line_err,
  output logic       o_frame_err
);

  localparam logic [9:0] HC_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  logic       w_hs;
  logic       w_vs;
  logic       r_hs_d;
  logic       r_vs_d;
  logic [9:0] r_hc;
  logic [9:0] r_vc;

  assign w_hs = i_hsync ^ SYNC_ACTIVE_LOW;
  assign w_vs = i_vsync ^ SYNC_ACTIVE_LOW;

  assign o_hs_start  = i_pixpulse & w_hs & ~r_hs_d;
  assign o_vs_start  = i_pixpulse & w_vs & ~r_vs_d;
  assign o_line_err  = o_hs_start & (r_hc != HC_LAST);
  assign o_frame_err = o_vs_start & (r_vc != VC_LAST);
  assign o_hc        = r_hc;
  assign o_vc        = r_vc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_hc   <= '0;
      r_vc   <= '0;
    end else if (i_pixpulse) begin
      r_hs_d <= w_hs;
      r_vs_d <= w_vs;
      if (o_hs_start)            r_hc <= '0;
      else if (r_hc != CNT_MAX)  r_hc <= r_hc + 10'd1;
      // A frame start restarts the line count even when hsync also starts.
      if (o_vs_start)                          r_vc <= '0;
      else if (o_hs_start && r_vc != CNT_MAX)  r_vc <= r_vc + 10'd1;
    end
  end

endmodule

// File: rtl/vga_stream_monitor.sv
// VGA self-test sink: lock FSM plus per-frame CRC, lit-pixel count and
// probe-pixel capture over the active window.
module vga_stream_monitor #(
  parameter int H_TOTAL         = vga_pkg::H_TOTAL,
  parameter int V_TOTAL         = vga_pkg::V_TOTAL,
  parameter int H_ACT_START     = vga_pkg::H_ACT_START,
  parameter int H_ACT_LEN       = vga_pkg::H_ACT_LEN,
  parameter int V_ACT_START     = vga_pkg::V_ACT_START,
  parameter int V_ACT_LEN       = vga_pkg::V_ACT_LEN,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int PROBE_X         = 320,
  parameter int PROBE_Y         = 240
) (
  input logic                 clk,
  input logic                 rst,
  vga_stream_monitor_if.slave mon
);
  import vga_pkg::*;

  localparam logic [9:0] H_LO  = 10'(H_ACT_START);
  localparam logic [9:0] H_HI  = 10'(H_ACT_START + H_ACT_LEN);
  localparam logic [9:0] V_LO  = 10'(V_ACT_START);
  localparam logic [9:0] V_HI  = 10'(V_ACT_START + V_ACT_LEN);
  localparam logic [9:0] PR_HC = 10'(H_ACT_START + PROBE_X);
  localparam logic [9:0] PR_VC = 10'(V_ACT_START + PROBE_Y);

  logic [9:0]  w_hc;
  logic [9:0]  w_vc;
  logic        w_hs_start;
  logic        w_vs_start;
  logic        w_line_err;
  logic        w_frame_err;
  logic        w_act;
  logic [9:0]  w_lines;

  mon_state_t  r_state;
  logic        r_bad;
  logic [15:0] r_crc;
  logic [18:0] r_lit;
  logic [11:0] r_probe;
  logic        r_locked;
  logic        r_frame_done;
  logic [15:0] r_frame_crc;
  logic [18:0] r_lit_count;
  logic [11:0] r_probe_rgb;
  logic [9:0]  r_meas_lines;
  logic        r_timing_err;

  vga_sync_tracker #(
    .H_TOTAL         (H_TOTAL),
    .V_TOTAL         (V_TOTAL),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .i_pixpulse  (mon.pixpulse),
    .i_hsync     (mon.hsync),
    .i_vsync     (mon.vsync),
    .o_hc        (w_hc),
    .o_vc        (w_vc),
    .o_hs_start  (w_hs_start),
    .o_vs_start  (w_vs_start),
    .o_line_err  (w_line_err),
    .o_frame_err (w_frame_err)
  );

  // Window uses the pre-update counters, so a pixel coinciding with
  // hs_start still belongs to the line that is ending.
  assign w_act   = (w_hc >= H_LO) && (w_hc < H_HI) && (w_vc >= V_LO) && (w_vc < V_HI);
  assign w_lines = (w_vc == 10'h3FF) ? 10'h3FF : w_vc + 10'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_UNLOCKED;
      r_bad        <= 1'b0;
      r_crc        <= CRC16_INIT;
      r_lit        <= '0;
      r_probe      <= '0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_crc  <= '0;
      r_lit_count  <= '0;
      r_probe_rgb  <= '0;
      r_meas_lines <= '0;
      r_timing_err <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (mon.pixpulse) begin
        if (w_vs_start) begin
          r_frame_crc  <= r_crc;
          r_lit_count  <= r_lit;
          r_probe_rgb  <= r_probe;
          r_meas_lines <= w_lines;
          r_crc        <= CRC16_INIT;
          r_lit        <= '0;
          r_frame_done <= (r_state != ST_UNLOCKED);
        end else if (w_act) begin
          r_crc <= crc16_step(r_crc, mon.rgb);
          r_lit <= r_lit + {18'd0, |mon.rgb};
          if (w_hc == PR_HC && w_vc == PR_VC) r_probe <= mon.rgb;
        end

        case (r_state)
          ST_UNLOCKED: begin
            if (w_vs_start) begin
              r_state <= ST_MEASURE;
              r_bad   <= 1'b0;
            end
          end
          ST_MEASURE: begin
            if (w_vs_start) begin
              r_bad <= 1'b0;
              if (!(r_bad || w_line_err || w_frame_err)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else if (w_line_err) begin
              r_bad <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (w_line_err || w_frame_err) begin
              r_state      <= ST_UNLOCKED;
              r_locked     <= 1'b0;
              r_timing_err <= 1'b1;
            end
          end
          default: begin
            r_state  <= ST_UNLOCKED;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mon.locked     = r_locked;
  assign mon.frame_done = r_frame_done;
  assign mon.frame_crc  = r_frame_crc;
  assign mon.lit_count  = r_lit_count;
  assign mon.probe_rgb  = r_probe_rgb;
  assign mon.meas_lines = r_meas_lines;
  assign mon.timing_err = r_timing_err;
  assign mon.dbg_state  = r_state;

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Bench for vga_stream_monitor on a reduced 20x12 raster (12x8 active) so
// whole frames stay short; frame results go through an expected queue.
module tb_vga_stream_monitor;

  localparam int H_T  = 20;
  localparam int H_AS = 4;
  localparam int H_AL = 12;
  localparam int V_T  = 12;
  localparam int V_AS = 2;
  localparam int V_AL = 8;
  localparam int PX   = 5;
  localparam int PY   = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [56:0] exp_q[$];
  logic [15:0] acc_crc;
  logic [18:0] acc_lit;
  logic [11:0] exp_probe;
  logic [9:0]  prev_lines;

  vga_stream_monitor_if src();

  vga_stream_monitor #(
    .H_TOTAL         (H_T),
    .V_TOTAL         (V_T),
    .H_ACT_START     (H_AS),
    .H_ACT_LEN       (H_AL),
    .V_ACT_START     (V_AS),
    .V_ACT_LEN       (V_AL),
    .SYNC_ACTIVE_LOW (1'b1),
    .PROBE_X         (PX),
    .PROBE_Y         (PY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (src)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [11:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 4'h0};
    for (int k = 0; k < 12; k++) begin
      if (c[15]) c = (c << 1) ^ 16'h1021;
      else       c = c << 1;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_locked"},     32'(src.locked),     32'd0);
    check({tag, "_frame_done"}, 32'(src.frame_done), 32'd0);
    check({tag, "_frame_crc"},  32'(src.frame_crc),  32'd0);
    check({tag, "_lit_count"},  32'(src.lit_count),  32'd0);
    check({tag, "_probe_rgb"},  32'(src.probe_rgb),  32'd0);
    check({tag, "_meas_lines"}, 32'(src.meas_lines), 32'd0);
    check({tag, "_timing_err"}, 32'(src.timing_err), 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic drive_pix(input logic hs, input logic vs, input logic [11:0] d);
    @(negedge clk);
    src.pixpulse = 1'b1;
    src.hsync    = hs;
    src.vsync    = vs;
    src.rgb      = d;
    @(negedge clk);
    src.pixpulse = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // mode 0: black, 1: solid white, 2: single 12'hf0a at the probe point.
  // Pixel slot p of a line lands at active x = p-1-H_AS (slot 0 is the
  // hsync-start pixel, which the monitor still counts against the old line).
  task automatic send_frame(input int n_lines, input int mode, input int short_line,
                            input bit expect_done);
    logic [11:0] d;
    int len, x, y;
    bit act;
    if (expect_done) exp_q.push_back({acc_crc, acc_lit, exp_probe, prev_lines});
    acc_crc    = 16'hFFFF;
    acc_lit    = '0;
    prev_lines = 10'(n_lines);
    for (int l = 0; l < n_lines; l++) begin
      len = (l == short_line) ? H_T - 1 : H_T;
      for (int p = 0; p < len; p++) begin
        x   = p - 1 - H_AS;
        y   = l - V_AS;
        act = (p >= 1) && (x >= 0) && (x < H_AL) && (y >= 0) && (y < V_AL);
        if (act) begin
          case (mode)
            1:       d = 12'hfff;
            2:       d = (x == PX && y == PY) ? 12'hf0a : 12'h000;
            default: d = 12'h000;
          endcase
          acc_crc = ref_crc(acc_crc, d);
          if (d != 12'h000) acc_lit = acc_lit + 19'd1;
          if (x == PX && y == PY) exp_probe = d;
        end else begin
          d = 12'($urandom_range(1, 4095));
        end
        drive_pix(p >= 3, l >= 2, d);
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [56:0] e;
    forever begin
      @(negedge clk);
      if (src.frame_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame_done: got 1, required 0 (no frame pending)");
        end else begin
          e = exp_q.pop_front();
          check("frame_crc",  32'(src.frame_crc),  32'(e[56:41]));
          check("lit_count",  32'(src.lit_count),  32'(e[40:22]));
          check("probe_rgb",  32'(src.probe_rgb),  32'(e[21:10]));
          check("meas_lines", 32'(src.meas_lines), 32'(e[9:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    src.pixpulse = 1'b0;
    src.hsync    = 1'b1;
    src.vsync    = 1'b1;
    src.rgb      = '0;
    acc_crc    = 16'hFFFF;
    acc_lit    = '0;
    exp_probe  = '0;
    prev_lines = '0;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    send_frame(V_T, 0, -1, 1'b0);
    check("locked_after_1st_vs", 32'(src.locked), 32'd0);
    send_frame(V_T, 0, -1, 1'b1);
    check("locked_after_2nd_vs", 32'(src.locked), 32'd1);
    check("terr_clean",          32'(src.timing_err), 32'd0);
    send_frame(V_T, 1, -1, 1'b1);
    send_frame(V_T, 2, -1, 1'b1);

    // Short line while locked: drop lock, sticky timing error.
    send_frame(V_T, 0, 5, 1'b1);
    check("locked_after_short_line", 32'(src.locked),     32'd0);
    check("terr_after_short_line",   32'(src.timing_err), 32'd1);
    send_frame(V_T, 0, -1, 1'b0);
    check("locked_relock_1st_vs", 32'(src.locked), 32'd0);
    send_frame(V_T, 0, -1, 1'b1);
    check("locked_relock_2nd_vs", 32'(src.locked),     32'd1);
    check("terr_still_set",       32'(src.timing_err), 32'd1);

    // One frame one line short while locked.
    send_frame(V_T - 1, 0, -1, 1'b1);
    send_frame(V_T, 0, -1, 1'b1);
    check("locked_after_short_frame", 32'(src.locked),     32'd0);
    check("terr_after_short_frame",   32'(src.timing_err), 32'd1);

    // Reset in the middle of a frame, then idle and relock.
    send_frame(4, 0, -1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    acc_crc   = 16'hFFFF;
    acc_lit   = '0;
    exp_probe = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) drive_pix(1'b1, 1'b1, 12'($urandom_range(0, 4095)));
    check("locked_idle", 32'(src.locked), 32'd0);
    send_frame(V_T, 0, -1, 1'b0);
    check("locked_post_rst_1st_vs", 32'(src.locked), 32'd0);
    send_frame(V_T, 2, -1, 1'b1);
    check("locked_post_rst_2nd_vs", 32'(src.locked),     32'd1);
    check("terr_post_rst",          32'(src.timing_err), 32'd0);

    repeat (8) @(negedge clk);
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
